pc_unit: RTL and testbench

Registered program-counter unit: the parametrised successor of the combinational next-PC adder. It holds the architectural PC and selects the next PC from sequential, branch, jump, jump-and-link and return sources. It captures the link address and, optionally, keeps a hardware return-address stack (RAS). It sits at the head of the fetch stage and drives the instruction-memory address. Stall handshakes with the hazard unit.

---
 rtl/pc_unit.sv | 150 +++++++++++++++
 tb/tb_pc_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - registered program counter with next-PC select, link capture and optional return-address stack
// Optional feature macro: PC_RAS_EN (defined = hardware return-address stack present)
module pc_unit #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        jal_en,
  input  logic                        ret_en,
  input  logic                        jump_en,
  input  logic                        branch_en,
  input  logic [WIDTH-1:0]            src2,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            rlink,
  output logic                        rlink_valid,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow
);

  localparam int PtrW = $clog2(RAS_DEPTH);
  localparam int CntW = PtrW + 1;

  // Winning next-PC source after priority resolution
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_RET,
    SEL_JAL
  } selT;

  selT              sel;
  logic [WIDTH-1:0] seqPc;
  logic [WIDTH-1:0] branchPc;
  logic [WIDTH-1:0] nextPc;
  logic [WIDTH-1:0] retPc;

  // Reject stack depths the circular pointer cannot address cleanly
  generate
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : gBadDepth
      $error("pc_unit: RAS_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  // Modulo-2^WIDTH adders; the link address is the sequential successor
  assign seqPc    = pc + WIDTH'(1);
  assign branchPc = pc + src2;

  // Fixed priority: jal > ret > jump > branch > sequential
  always_comb begin
    sel = SEL_SEQ;
    if (jal_en)         sel = SEL_JAL;
    else if (ret_en)    sel = SEL_RET;
    else if (jump_en)   sel = SEL_JUMP;
    else if (branch_en) sel = SEL_BRANCH;
  end

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] rasMem [RAS_DEPTH];
  logic [PtrW-1:0]  rasPtr;
  logic [CntW-1:0]  rasCnt;
  logic             rasOvf;
  logic             rasUnf;
  logic             rasEmpty;
  logic             rasFull;
  logic [WIDTH-1:0] rasTop;

  assign rasEmpty = (rasCnt == '0);
  assign rasFull  = (rasCnt == CntW'(RAS_DEPTH));
  // rasPtr names the next free slot, so the top sits one below it
  assign rasTop   = rasMem[rasPtr - PtrW'(1)];
  // An empty stack falls back to the supplied target
  assign retPc    = rasEmpty ? src2 : rasTop;

  // Stack storage: pushes land on the free slot, wrapping onto the oldest entry when full
  always_ff @(posedge clk) begin
    if (reset && !stall && sel == SEL_JAL) begin
      rasMem[rasPtr] <= seqPc;
    end
  end

  // Stack pointer, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      rasPtr <= '0;
      rasCnt <= '0;
      rasOvf <= 1'b0;
      rasUnf <= 1'b0;
    end else if (!stall) begin
      if (sel == SEL_JAL) begin
        rasPtr <= rasPtr + PtrW'(1);
        if (rasFull) rasOvf <= 1'b1;
        else         rasCnt <= rasCnt + CntW'(1);
      end else if (sel == SEL_RET) begin
        if (rasEmpty) begin
          rasUnf <= 1'b1;
        end else begin
          rasPtr <= rasPtr - PtrW'(1);
          rasCnt <= rasCnt - CntW'(1);
        end
      end
    end
  end

  assign ras_count     = rasCnt;
  assign ras_overflow  = rasOvf;
  assign ras_underflow = rasUnf;
`else
  // Without a stack a return is simply an absolute jump
  assign retPc         = src2;
  assign ras_count     = '0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  // Next-PC multiplexer driven by the resolved source
  always_comb begin
    nextPc = seqPc;
    case (sel)
      SEL_JAL:    nextPc = src2;
      SEL_RET:    nextPc = retPc;
      SEL_JUMP:   nextPc = src2;
      SEL_BRANCH: nextPc = branchPc;
      default:    nextPc = seqPc;
    endcase
  end

  // Architectural PC and link register; the valid pulse drops on any non-JAL cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_VECTOR;
      rlink       <= '0;
      rlink_valid <= 1'b0;
    end else begin
      rlink_valid <= 1'b0;
      if (!stall) begin
        pc <= nextPc;
        if (sel == SEL_JAL) begin
          rlink       <= seqPc;
          rlink_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RasOn = 1'b1;
`else
  localparam bit RasOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jal_en;
  logic        ret_en;
  logic        jump_en;
  logic        branch_en;
  logic [15:0] src2;
  logic [15:0] pc;
  logic [15:0] rlink;
  logic        rlink_valid;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int compared   = 0;
  int mismatched = 0;

  pc_unit #(
    .WIDTH(16),
    .RESET_VECTOR(16'h0010),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .jal_en(jal_en),
    .ret_en(ret_en),
    .jump_en(jump_en),
    .branch_en(branch_en),
    .src2(src2),
    .pc(pc),
    .rlink(rlink),
    .rlink_valid(rlink_valid),
    .ras_count(ras_count),
    .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic j, input logic r, input logic jp, input logic b, input logic [15:0] s);
    jal_en    = j;
    ret_en    = r;
    jump_en   = jp;
    branch_en = b;
    src2      = s;
  endtask

  task automatic flags(input string tag, input logic [2:0] cnt, input logic ovf, input logic unf);
    checkVal({tag, "_cnt"}, 32'(ras_count), 32'(cnt));
    checkVal({tag, "_ovf"}, 32'(ras_overflow), 32'(ovf));
    checkVal({tag, "_unf"}, 32'(ras_underflow), 32'(unf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] origins [5];
    logic [15:0] retExp;
    origins[0] = 16'h000A; origins[1] = 16'h001A; origins[2] = 16'h002A;
    origins[3] = 16'h003A; origins[4] = 16'h004A;

    reset = 1'b0; stall = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    #2;
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkVal("rst_pc", 32'(pc), 32'h0010);
    checkVal("rst_rlink", 32'(rlink), 32'h0000);
    checkVal("rst_rv", 32'(rlink_valid), 32'h0);
    flags("rst", 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkVal($sformatf("seq_%0d", i), 32'(pc), 32'h0010 + 32'(i));
    end

    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020); tick();
    checkVal("jump_20", 32'(pc), 32'h0020);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFC); tick();
    checkVal("branch_neg", 32'(pc), 32'h001C);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0200); tick();
    checkVal("jump_over_branch", 32'(pc), 32'h0200);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    checkVal("wrap", 32'(pc), 32'h0000);
    checkVal("no_rv", 32'(rlink_valid), 32'h0);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0400); tick();
    checkVal("jal_pc", 32'(pc), 32'h0400);
    checkVal("jal_rlink", 32'(rlink), 32'h0101);
    checkVal("jal_rv", 32'(rlink_valid), 32'h1);
    flags("jal", RasOn ? 3'd1 : 3'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    checkVal("jal_rv_drop", 32'(rlink_valid), 32'h0);
    checkVal("jal_seq", 32'(pc), 32'h0401);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0777); tick();
    checkVal("ret_pc", 32'(pc), RasOn ? 32'h0101 : 32'h0777);
    flags("ret", 3'd0, 1'b0, 1'b0);

    drive(1'b0, 1'b0, 1'b1, 1'b0, origins[0]); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, (i < 4) ? origins[i+1] : 16'h0500); tick();
    end
    checkVal("ovf_rlink", 32'(rlink), 32'h004B);
    flags("ovf", RasOn ? 3'd4 : 3'd0, RasOn, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0900 + 16'(i));
      tick();
      retExp = RasOn ? (origins[4-i] + 16'h0001) : (16'h0900 + 16'(i));
      checkVal($sformatf("lifo_%0d", i), 32'(pc), 32'(retExp));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0300); tick();
    checkVal("unf_pc", 32'(pc), 32'h0300);
    flags("unf", 3'd0, RasOn, RasOn);

    stall = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0600);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal($sformatf("stall_pc_%0d", i), 32'(pc), 32'h0300);
      checkVal($sformatf("stall_rl_%0d", i), 32'(rlink), 32'h004B);
      checkVal($sformatf("stall_rv_%0d", i), 32'(rlink_valid), 32'h0);
      checkVal($sformatf("stall_cnt_%0d", i), 32'(ras_count), 32'h0);
    end
    stall = 1'b0; tick();
    checkVal("unstall_pc", 32'(pc), 32'h0600);
    checkVal("unstall_rl", 32'(rlink), 32'h0301);
    checkVal("unstall_rv", 32'(rlink_valid), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0700); tick();
    checkVal("jal2_rl", 32'(rlink), 32'h0601);
    flags("jal2", RasOn ? 3'd2 : 3'd0, RasOn, RasOn);

    reset = 1'b0; stall = 1'b1; tick();
    reset = 1'b1; stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkVal("rst2_pc", 32'(pc), 32'h0010);
    checkVal("rst2_rl", 32'(rlink), 32'h0000);
    checkVal("rst2_rv", 32'(rlink_valid), 32'h0);
    flags("rst2", 3'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0055); tick();
    checkVal("ret55_pc", 32'(pc), 32'h0055);
    flags("ret55", 3'd0, 1'b0, RasOn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
